// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types for the forwarding / load-use hazard unit: write-enable encoding,
// stall FSM states and the legacy two-stage forwarding source encoding.
package fwd_hazard_unit_pkg;

  typedef enum logic {
    MEM_NO_WRITE = 1'b0,
    MEM_WRITE    = 1'b1
  } mem_write_signal;

  localparam int DEFAULT_NUM_FWD_STAGES = 2;
  localparam int FWD_SEL_W = $clog2(DEFAULT_NUM_FWD_STAGES + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } fwd_state_t;

  // Select encoding used by the original two-stage (MEM/WB) forwarding unit.
  typedef enum logic [FWD_SEL_W-1:0] {
    FROM_DECODE = 2'd0,
    FROM_MEM    = 2'd1,
    FROM_WB     = 2'd2
  } forwarding_data_source;

endpackage

// File: rtl/fwd_port_select.sv
// Forwarding source select for one EX operand port: the youngest writing stage
// whose destination matches wins; ZERO_REG is never forwarded.
module fwd_port_select
  import fwd_hazard_unit_pkg::*;
#(
  parameter int ADDR_WIDTH     = 5,
  parameter int NUM_FWD_STAGES = 2,
  parameter int ZERO_REG       = 31,
  parameter int SEL_W          = 2
) (
  input  logic            [ADDR_WIDTH-1:0]                     src_addr_i,
  input  logic            [NUM_FWD_STAGES-1:0][ADDR_WIDTH-1:0] stage_dest_i,
  input  mem_write_signal [NUM_FWD_STAGES-1:0]                 stage_write_en_i,
  output logic            [SEL_W-1:0]                          sel_o
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_o = '0;
    // Walk from oldest to youngest so the lowest matching index is written last.
    for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
      if (stage_write_en_i[k] == MEM_WRITE && stage_dest_i[k] == src_addr_i) begin
        sel_o = SEL_W'(k + 1);
      end
    end
    if (src_addr_i == ADDR_WIDTH'(ZERO_REG)) begin
      sel_o = '0;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding for NUM_SRC ports plus a load-use stall controller.
// Optional saturating statistics counters are built when FWD_HAZARD_STATS_EN is defined.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int ADDR_WIDTH        = 5,
  parameter int NUM_SRC           = 2,
  parameter int NUM_FWD_STAGES    = 2,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int ZERO_REG          = 31,
  parameter int STAT_WIDTH        = 32,
  localparam int SEL_W            = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                                         clk_i,
  input  logic                                         rst_n_i,
  input  logic            [NUM_SRC-1:0][ADDR_WIDTH-1:0]        ex_src_addr_i,
  input  logic            [NUM_FWD_STAGES-1:0][ADDR_WIDTH-1:0] stage_dest_i,
  input  mem_write_signal [NUM_FWD_STAGES-1:0]                 stage_write_en_i,
  input  logic            [NUM_SRC-1:0][ADDR_WIDTH-1:0]        id_src_addr_i,
  input  logic            [NUM_SRC-1:0]                        id_src_valid_i,
  input  logic            [ADDR_WIDTH-1:0]                     ex_dest_i,
  input  logic                                                 ex_is_load_i,
  input  mem_write_signal                                      ex_write_en_i,
  input  logic                                                 flush_i,
  output logic            [NUM_SRC-1:0][SEL_W-1:0]             fwd_sel_o,
  output logic                                                 stall_o,
  output logic                                                 bubble_o
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic            [STAT_WIDTH-1:0]                     stall_cnt_o,
  output logic            [STAT_WIDTH-1:0]                     fwd_cnt_o
`endif
);

  localparam int CNT_W = $clog2(LOAD_STALL_CYCLES + 1);

  if (LOAD_STALL_CYCLES < 1 || STAT_WIDTH < 1) begin : g_bad_cfg
    $error("fwd_hazard_unit: LOAD_STALL_CYCLES and STAT_WIDTH must be at least 1");
  end

  // ---------------- forwarding ----------------
  for (genvar p = 0; p < NUM_SRC; p++) begin : g_port
    fwd_port_select #(
      .ADDR_WIDTH    (ADDR_WIDTH),
      .NUM_FWD_STAGES(NUM_FWD_STAGES),
      .ZERO_REG      (ZERO_REG),
      .SEL_W         (SEL_W)
    ) u_sel (
      .src_addr_i      (ex_src_addr_i[p]),
      .stage_dest_i    (stage_dest_i),
      .stage_write_en_i(stage_write_en_i),
      .sel_o           (fwd_sel_o[p])
    );
  end

  // ---------------- load-use detection ----------------
  logic hazard;

  always_comb begin
    hazard = 1'b0;
    if (ex_is_load_i && ex_write_en_i == MEM_WRITE &&
        ex_dest_i != ADDR_WIDTH'(ZERO_REG)) begin
      for (int p = 0; p < NUM_SRC; p++) begin
        if (id_src_valid_i[p] && id_src_addr_i[p] == ex_dest_i) begin
          hazard = 1'b1;
        end
      end
    end
  end

  // ---------------- stall FSM ----------------
  fwd_state_t       state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic             stall_raw;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    stall_raw  = 1'b0;
    unique case (state)
      IDLE: begin
        stall_raw = hazard;
        if (hazard && LOAD_STALL_CYCLES > 1) begin
          next_state = STALL;
          next_cnt   = CNT_W'(LOAD_STALL_CYCLES - 1);
        end
      end
      STALL: begin
        stall_raw = 1'b1;
        next_cnt  = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          next_state = IDLE;
          next_cnt   = '0;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
    // A redirect cancels both the current stall and any pending sequence.
    if (flush_i) begin
      stall_raw  = 1'b0;
      next_state = IDLE;
      next_cnt   = '0;
    end
  end

  assign stall_o  = stall_raw & rst_n_i;
  assign bubble_o = stall_o;

`ifdef FWD_HAZARD_STATS_EN
  // ---------------- statistics ----------------
  logic any_fwd;
  assign any_fwd = |fwd_sel_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
      fwd_cnt_o   <= '0;
    end else begin
      if (stall_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + STAT_WIDTH'(1);
      if (any_fwd && fwd_cnt_o != '1)   fwd_cnt_o   <= fwd_cnt_o + STAT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the pipelined core. Generalises two-stage ALU operand forwarding to NUM_SRC operand ports and NUM_FWD_STAGES producer stages, and adds a load-use stall controller with a multi-cycle stall counter. Sits between decode/execute and the later pipeline stages. It drives the EX operand muxes and the IF/ID stall and bubble controls.

## Interface
- ADDR_WIDTH, 5: register address width.
- NUM_SRC, 2: operand ports forwarded and checked for load-use.
- NUM_FWD_STAGES, 2: producer stages. Index 0 is youngest (MEM), then WB, and so on.
- LOAD_STALL_CYCLES, 1: stall length per load-use hazard, ≥1.
- ZERO_REG, 31: register that is never forwarded and never causes a stall.
- STAT_WIDTH, 32: width of the statistics counters.

Ports:
- clk_i  in  1  core clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- ex_src_addr_i  in  NUM_SRC×ADDR_WIDTH  EX operand addresses.
- stage_dest_i  in  NUM_FWD_STAGES×ADDR_WIDTH  destination register of each producer stage.
- stage_write_en_i  in  NUM_FWD_STAGES×mem_write_signal  per-stage write enable (MEM_WRITE means it writes).
- id_src_addr_i  in  NUM_SRC×ADDR_WIDTH  decode operand addresses.
- id_src_valid_i  in  NUM_SRC  decode operand actually read.
- ex_dest_i  in  ADDR_WIDTH  EX destination register.
- ex_is_load_i  in  1  EX instruction is a load.
- ex_write_en_i  in  mem_write_signal  EX write enable.
- flush_i  in  1  pipeline flush (branch redirect).
- fwd_sel_o  out  NUM_SRC×FWD_SEL_W  per-port source select. 0 selects the decode value; k selects stage k-1.
- stall_o  out  1  hold PC and IF/ID.
- bubble_o  out  1  insert a NOP into ID/EX.
- stall_cnt_o, fwd_cnt_o  out  STAT_WIDTH  present only with the statistics macro.

## Operation
- **Forwarding** (combinational):
  - For each port, select the lowest-index stage with MEM_WRITE whose dest equals ex_src_addr_i.
  - A port whose address is ZERO_REG always selects 0.
  - If no stage matches, select 0.
- **Hazard** (combinational): asserted when all of the following hold:
  - ex_is_load_i is high and ex_write_en_i==MEM_WRITE;
  - ex_dest_i≠ZERO_REG;
  - some port has id_src_valid_i high and id_src_addr_i==ex_dest_i.
- **Stall FSM**, states IDLE and STALL, with down-counter cnt of width $clog2(LOAD_STALL_CYCLES+1):
  - IDLE: stall_o=bubble_o=hazard. If hazard, flush_i is low and LOAD_STALL_CYCLES>1, go to STALL with cnt=LOAD_STALL_CYCLES-1.
  - STALL: stall_o=bubble_o=1 and cnt decrements. When cnt==1, return to IDLE. New hazards are ignored while in STALL.
- **Flush**:
  - flush_i forces stall_o=bubble_o=0 in the same cycle.
  - Next state is IDLE with cnt=0. This holds in both states and takes priority over a simultaneous hazard.
- **Reset** (asserted at any time, including mid-stall):
  - State goes to IDLE, cnt to 0 and statistics to 0.
  - stall_o and bubble_o are forced to 0 while rst_n_i is low.
  - fwd_sel_o stays purely combinational.

## Timing
- fwd_sel_o has zero-cycle latency from its inputs.
- stall_o is Mealy in IDLE (same cycle as the hazard) and Moore in STALL.
- Each hazard produces exactly LOAD_STALL_CYCLES consecutive stall cycles unless flushed.
- Back-to-back hazards: a hazard seen in IDLE on the cycle after STALL exits starts a new stall sequence.
- State and counters update on the rising edge of clk_i.

## Configuration
- FWD_HAZARD_STATS_EN defined:
  - stall_cnt_o increments on each cycle with stall_o high.
  - fwd_cnt_o increments on each cycle in which any port selects a nonzero source.
  - Both saturate at all-ones and clear only on reset.
- FWD_HAZARD_STATS_EN undefined: the counter ports and logic are absent.

## Structure
- Shared package holds:
  - mem_write_signal and MEM_WRITE;
  - FWD_SEL_W = $clog2(NUM_FWD_STAGES+1);
  - the fwd_state_t enum (IDLE, STALL);
  - forwarding_data_source, kept for 2-stage compatibility, with FROM_DECODE=0, FROM_MEM=1, FROM_WB=2.
- Sub-module fwd_port_select handles one operand port with a priority match over stages and is instantiated NUM_SRC times.

## Test plan
- **MEM/WB priority:** Both stages write r3 and EX src0=r3 → fwd_sel_o[0]=1. With only WB writing r3 → 2. With neither writing → 0.
- **ZERO_REG:** MEM writes r31 and src1=r31 → fwd_sel_o[1]=0. A load to r31 with ID using r31 → stall_o=0.
- **Three-cycle stall:** LOAD_STALL_CYCLES=3, load to r5 in EX, ID src1=r5 valid → stall_o=bubble_o=1 for exactly 3 cycles, then 0.
- **Invalid operand:** The same load with ID src0=r5 but id_src_valid_i[0]=0 → no stall.
- **Flush:** flush_i is raised in the 2nd stall cycle → stall_o=0 that cycle and the FSM is in IDLE next cycle. Separately, flush_i together with a hazard in IDLE → stall_o=0.
- **Reset mid-stall and statistics:** rst_n_i is pulsed low mid-stall → stall_o=0 immediately and the FSM is in IDLE after release. With FWD_HAZARD_STATS_EN defined, 2 stall cycles give stall_cnt_o=2, and a counter preloaded to the all-ones value stays at all-ones.
